// File: rtl/spi_sample_bridge_if.sv
// Bus between the SPI sample bridge and its neighbours: the SPI slave's
// frame/packet signals, the RX/TX handshakes to the FIR filter, and status.
interface spi_sample_bridge_if #(
    parameter int DATA_WIDTH = 16,
    parameter int RX_DEPTH   = 8,
    parameter int TX_DEPTH   = 8
);
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;

    logic                  sckIn;
    logic                  busyIn;
    logic                  dataReceivedIn;
    logic [DATA_WIDTH-1:0] packetIn;
    logic [DATA_WIDTH-1:0] packetOut;
    logic [DATA_WIDTH-1:0] rxDataOut;
    logic                  rxValidOut;
    logic                  rxReadyIn;
    logic [DATA_WIDTH-1:0] txDataIn;
    logic                  txValidIn;
    logic                  txReadyOut;
    logic                  clearIn;
    logic                  rxOverflowOut;
    logic                  txUnderflowOut;
    logic [7:0]            underflowCountOut;
    logic [RX_LW-1:0]      rxLevelOut;
    logic [TX_LW-1:0]      txLevelOut;

    // Bridge side
    modport slave (
        input  sckIn, busyIn, dataReceivedIn, packetIn, rxReadyIn,
               txDataIn, txValidIn, clearIn,
        output packetOut, rxDataOut, rxValidOut, txReadyOut,
               rxOverflowOut, txUnderflowOut, underflowCountOut,
               rxLevelOut, txLevelOut
    );

    // Driver side (SPI slave + filter, or a bench)
    modport master (
        output sckIn, busyIn, dataReceivedIn, packetIn, rxReadyIn,
               txDataIn, txValidIn, clearIn,
        input  packetOut, rxDataOut, rxValidOut, txReadyOut,
               rxOverflowOut, txUnderflowOut, underflowCountOut,
               rxLevelOut, txLevelOut
    );
endinterface

// File: rtl/spi_sample_bridge.sv
// Buffering stage between the SPI slave and the FIR datapath.
// RX: every completed SPI packet is queued and offered to the filter
// (show-ahead, valid/ready). TX: filter results are queued and the head is
// presented to the slave; the head advances exactly when the slave latches
// it (frame start, or the first SCK falling edge after a packet completes).
module spi_sample_bridge #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    RX_DEPTH       = 8,
    parameter int                    TX_DEPTH       = 8,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_WORD = 16'h0000
) (
    input logic                clkIn,
    input logic                resetIn,
    spi_sample_bridge_if.slave bus
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [RX_AW-1:0]      rx_wr, rx_rd;
    logic [TX_AW-1:0]      tx_wr, tx_rd;
    logic [RX_AW:0]        rx_level;
    logic [TX_AW:0]        tx_level;

    logic       sck_prev, busy_prev, load_pending;
    logic       rx_overflow, tx_underflow;
    logic [7:0] underflow_count;

    logic frame_start, sck_fall, consume;
    logic rx_pop, rx_push, rx_drop;
    logic tx_push, tx_pop, tx_underflow_evt;

    // Edge detection against the registered copies, matching the slave's view
    assign frame_start = bus.busyIn && !busy_prev;
    assign sck_fall    = sck_prev && !bus.sckIn;
    assign consume     = frame_start || (load_pending && sck_fall);

    // A full RX FIFO still accepts a push when the head leaves in the same cycle
    assign rx_pop  = (rx_level != '0) && bus.rxReadyIn;
    assign rx_push = bus.dataReceivedIn && ((rx_level != RX_FULL) || rx_pop);
    assign rx_drop = bus.dataReceivedIn && !rx_push;

    assign tx_push          = bus.txValidIn && (tx_level != TX_FULL);
    assign tx_pop           = consume && (tx_level != '0);
    assign tx_underflow_evt = consume && (tx_level == '0);

    assign bus.packetOut         = (tx_level != '0) ? tx_mem[tx_rd] : UNDERFLOW_WORD;
    assign bus.rxDataOut         = rx_mem[rx_rd];
    assign bus.rxValidOut        = (rx_level != '0);
    assign bus.txReadyOut        = (tx_level != TX_FULL);
    assign bus.rxOverflowOut     = rx_overflow;
    assign bus.txUnderflowOut    = tx_underflow;
    assign bus.underflowCountOut = underflow_count;
    assign bus.rxLevelOut        = rx_level;
    assign bus.txLevelOut        = tx_level;

    // FIFO storage: data only, no reset needed since levels gate visibility
    always_ff @(posedge clkIn) begin
        if (rx_push) rx_mem[rx_wr] <= bus.packetIn;
        if (tx_push) tx_mem[tx_wr] <= bus.txDataIn;
    end

    // Edge-detect history and the pending-reload tracker
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            sck_prev     <= 1'b0;
            busy_prev    <= 1'b0;
            load_pending <= 1'b0;
        end else begin
            sck_prev  <= bus.sckIn;
            busy_prev <= bus.busyIn;
            // A freshly completed packet arms the reload for the next SCK fall
            if (bus.dataReceivedIn)
                load_pending <= 1'b1;
            else if (sck_fall || frame_start || !bus.busyIn)
                load_pending <= 1'b0;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)
                rx_level <= rx_level + 1'b1;
            else if (rx_pop && !rx_push)
                rx_level <= rx_level - 1'b1;
        end
    end

    // TX FIFO pointers and occupancy; pops happen only on slave load events
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (tx_push && !tx_pop)
                tx_level <= tx_level + 1'b1;
            else if (tx_pop && !tx_push)
                tx_level <= tx_level - 1'b1;
        end
    end

    // Sticky status and underflow counter; a new event beats clearIn
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            rx_overflow     <= 1'b0;
            tx_underflow    <= 1'b0;
            underflow_count <= 8'd0;
        end else begin
            if (rx_drop)
                rx_overflow <= 1'b1;
            else if (bus.clearIn)
                rx_overflow <= 1'b0;

            if (tx_underflow_evt) begin
                tx_underflow    <= 1'b1;
                underflow_count <= bus.clearIn ? 8'd1 : sat_inc(underflow_count);
            end else if (bus.clearIn) begin
                tx_underflow    <= 1'b0;
                underflow_count <= 8'd0;
            end
        end
    end
endmodule
